dmem_responder: RTL and testbench

Data-memory responder for the pipelined RISC-V core's external data-memory port. It accepts the core's store requests (word, halfword, byte) and merges store data into the addressed byte lanes of a word-organised array. It returns the addressed aligned word combinationally so the core's memory stage can register it in the same cycle. After every reset it clears the whole array with an internal sequencer, and it flags illegal or misaligned stores with a sticky error.

---
 rtl/dmem_responder.sv | 82 ++++++++
 tb/tb_dmem_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: byte-lane store merge into a word array with post-reset clear and sticky store-error capture
module dmem_responder #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 11
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_dmem_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dmem_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_dmem_wdata,
    input  logic [1:0]                   i_storetype,
    output logic [P_DATA_WIDTH-1:0]      o_dmem_rdata,
    output logic                         o_init_done,
    output logic                         o_store_err,
    output logic [P_DMEM_ADDR_WIDTH-1:0] o_err_addr,
    input  logic                         i_err_clr
);
    localparam int WA    = P_DMEM_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WA;
    localparam logic S_INIT = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic                         state_q, state_d;
    logic [WA-1:0]                cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic [P_DMEM_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [P_DATA_WIDTH-1:0]      mem_q [DEPTH];

    logic [WA-1:0]           word_idx, wr_idx;
    logic [3:0]              st_be, wr_be;
    logic [P_DATA_WIDTH-1:0] st_data, wr_data;
    logic                    run, legal, drop;

    assign word_idx = i_dmem_addr[P_DMEM_ADDR_WIDTH-1:2];
    assign run      = state_q == S_RUN;

    always_comb begin
        legal   = i_storetype == 2'b10 ||
                  (i_storetype == 2'b01 && !i_dmem_addr[0]) ||
                  (i_storetype == 2'b00 && i_dmem_addr[1:0] == 2'b00);
        drop    = run && i_dmem_we && !legal;
        st_be   = i_storetype == 2'b00 ? 4'b1111 :
                  i_storetype == 2'b01 ? (i_dmem_addr[1] ? 4'b1100 : 4'b0011) :
                  4'b0001 << i_dmem_addr[1:0];
        st_data = i_storetype == 2'b00 ? i_dmem_wdata :
                  i_storetype == 2'b01 ? {2{i_dmem_wdata[15:0]}} : {4{i_dmem_wdata[7:0]}};
        // The clear sequencer owns the write port until RUN
        wr_idx  = run ? word_idx : cnt_q;
        wr_data = run ? st_data : '0;
        wr_be   = i_rst ? 4'b0000 : !run ? 4'b1111 : (i_dmem_we && legal) ? st_be : 4'b0000;
        state_d = run || &cnt_q ? S_RUN : S_INIT;
        cnt_d   = run ? cnt_q : cnt_q + 1'b1;
        err_d   = drop ? 1'b1 : i_err_clr ? 1'b0 : err_q;
        // A fresh error beats a simultaneous clear; otherwise the first error is held
        err_addr_d = drop && (!err_q || i_err_clr) ? i_dmem_addr :
                     i_err_clr ? '0 : err_addr_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++)
            if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end

    assign o_dmem_rdata = run ? mem_q[word_idx] : '0;
    assign o_init_done  = run;
    assign o_store_err  = err_q;
    assign o_err_addr   = err_addr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard-driven bench for the data-memory responder
module tb_dmem_responder;
    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, err_clr = 1'b0;
    logic [10:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  st = '0;
    logic [31:0] rdata;
    logic        init_done, store_err;
    logic [10:0] err_addr;
    int          vectors = 0, miscompares = 0;
    logic [31:0] sb [$];

    dmem_responder dut (
        .i_clk(clk), .i_rst(rst), .i_dmem_we(we), .i_dmem_addr(addr),
        .i_dmem_wdata(wdata), .i_storetype(st), .o_dmem_rdata(rdata),
        .o_init_done(init_done), .o_store_err(store_err), .o_err_addr(err_addr),
        .i_err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [10:0] a, input logic [31:0] d, input logic [1:0] t);
        we = 1'b1; addr = a; wdata = d; st = t;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] ra [3] = '{11'h000, 11'h3FC, 11'h7FC};
        int n = 0;
        rst = 1'b1;
        repeat (3) tick();
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        vectors++; if (store_err !== 1'b0) begin miscompares++; $display("FAIL rst_store_err: got %b want 0", store_err); end
        vectors++; if (err_addr !== 11'h0) begin miscompares++; $display("FAIL rst_err_addr: got %h want 000", err_addr); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 00000000", rdata); end
        rst = 1'b0;
        while (!init_done && n < 600) begin
            tick();
            n++;
            if (n == 5) begin we = 1'b1; addr = 11'h000; wdata = 32'hCAFEF00D; st = 2'b00; end
            if (n == 6) addr = 11'h002;
            if (n == 7) we = 1'b0;
        end
        vectors++; if (n != 512) begin miscompares++; $display("FAIL clear_edges: got %0d want 512", n); end
        vectors++; if (store_err !== 1'b0) begin miscompares++; $display("FAIL init_store_err: got %b want 0", store_err); end
        foreach (ra[i]) sb.push_back(32'h0);
        foreach (ra[i]) begin
            logic [31:0] exp;
            addr = ra[i]; #1;
            exp = sb.pop_front();
            vectors++; if (rdata !== exp) begin miscompares++; $display("FAIL clear_read @%h: got %h want %h", ra[i], rdata, exp); end
        end
    endtask

    task automatic test_sw();
        logic [10:0] ra [2] = '{11'h010, 11'h013};
        we = 1'b1; addr = 11'h010; wdata = 32'hDEADBEEF; st = 2'b00; #1;
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rdw_old: got %h want 00000000", rdata); end
        tick();
        we = 1'b0;
        foreach (ra[i]) sb.push_back(32'hDEADBEEF);
        foreach (ra[i]) begin
            logic [31:0] exp;
            addr = ra[i]; #1;
            exp = sb.pop_front();
            vectors++; if (rdata !== exp) begin miscompares++; $display("FAIL sw_read @%h: got %h want %h", ra[i], rdata, exp); end
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] exp;
        store(11'h020, 32'h0, 2'b00);
        store(11'h021, 32'hFFFFFFAA, 2'b10);
        store(11'h023, 32'h12345655, 2'b10);
        sb.push_back(32'h5500AA00);
        addr = 11'h020; #1;
        exp = sb.pop_front();
        vectors++; if (rdata !== exp) begin miscompares++; $display("FAIL byte_lanes: got %h want %h", rdata, exp); end
        vectors++; if (store_err !== 1'b0) begin miscompares++; $display("FAIL sb_no_err: got %b want 0", store_err); end
    endtask

    task automatic test_halfword();
        logic [31:0] exp;
        store(11'h030, 32'h11223344, 2'b00);
        store(11'h032, 32'hA5A5BEEF, 2'b01);
        sb.push_back(32'hBEEF3344);
        addr = 11'h030; #1;
        exp = sb.pop_front();
        vectors++; if (rdata !== exp) begin miscompares++; $display("FAIL halfword: got %h want %h", rdata, exp); end
        vectors++; if (store_err !== 1'b0) begin miscompares++; $display("FAIL sh_no_err: got %b want 0", store_err); end
    endtask

    task automatic test_dropped();
        logic [10:0] ra [3] = '{11'h040, 11'h044, 11'h050};
        store(11'h041, 32'hFFFFFFFF, 2'b01);
        store(11'h046, 32'hFFFFFFFF, 2'b00);
        vectors++; if (store_err !== 1'b1) begin miscompares++; $display("FAIL drop_err: got %b want 1", store_err); end
        vectors++; if (err_addr !== 11'h041) begin miscompares++; $display("FAIL drop_addr: got %h want 041", err_addr); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        vectors++; if (store_err !== 1'b0) begin miscompares++; $display("FAIL clr_err: got %b want 0", store_err); end
        vectors++; if (err_addr !== 11'h0) begin miscompares++; $display("FAIL clr_addr: got %h want 000", err_addr); end
        store(11'h050, 32'hFFFFFFFF, 2'b11);
        vectors++; if (store_err !== 1'b1) begin miscompares++; $display("FAIL rsvd_err: got %b want 1", store_err); end
        vectors++; if (err_addr !== 11'h050) begin miscompares++; $display("FAIL rsvd_addr: got %h want 050", err_addr); end
        err_clr = 1'b1;
        store(11'h061, 32'hFFFFFFFF, 2'b01);
        err_clr = 1'b0;
        vectors++; if (store_err !== 1'b1) begin miscompares++; $display("FAIL clr_race_err: got %b want 1", store_err); end
        vectors++; if (err_addr !== 11'h061) begin miscompares++; $display("FAIL clr_race_addr: got %h want 061", err_addr); end
        foreach (ra[i]) sb.push_back(32'h0);
        foreach (ra[i]) begin
            logic [31:0] exp;
            addr = ra[i]; #1;
            exp = sb.pop_front();
            vectors++; if (rdata !== exp) begin miscompares++; $display("FAIL drop_unchanged @%h: got %h want %h", ra[i], rdata, exp); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        int n = 0;
        store(11'h100, 32'h12345678, 2'b00);
        sb.push_back(32'h12345678);
        addr = 11'h100; #1;
        exp = sb.pop_front();
        vectors++; if (rdata !== exp) begin miscompares++; $display("FAIL pre_reset_read: got %h want %h", rdata, exp); end
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL mid_init_done: got %b want 0", init_done); end
        vectors++; if (store_err !== 1'b0) begin miscompares++; $display("FAIL mid_store_err: got %b want 0", store_err); end
        vectors++; if (err_addr !== 11'h0) begin miscompares++; $display("FAIL mid_err_addr: got %h want 000", err_addr); end
        while (!init_done && n < 600) begin
            tick();
            n++;
        end
        vectors++; if (n != 512) begin miscompares++; $display("FAIL mid_clear_edges: got %0d want 512", n); end
        sb.push_back(32'h0);
        addr = 11'h100; #1;
        exp = sb.pop_front();
        vectors++; if (rdata !== exp) begin miscompares++; $display("FAIL post_reset_read: got %h want %h", rdata, exp); end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_byte_lanes();
        test_halfword();
        test_dropped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
